boot_loader_rv32i: RTL and testbench

Boot/program-load controller for the single-cycle RV32I core.
- Holds the core in reset while a host streams a program over a byte valid/ready link.
- Packs the bytes into little-endian 32-bit words and writes them into the instruction memory's write port.
- Releases the core so it fetches from PC 0 with the new image.
- Sits between the top-level reset/host interface and the core's rst_n and imem write port.

---
 rtl/boot_loader_rv32i_pkg.sv | 22 ++
 rtl/boot_loader_rv32i_if.sv | 20 ++
 rtl/boot_loader_rv32i_packer.sv | 38 +++
 rtl/boot_loader_rv32i.sv | 126 ++++++++++++
 tb/tb_boot_loader_rv32i.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_rv32i_pkg.sv
// Shared types and constants for the RV32I boot loader: FSM states,
// header/word geometry and the word-index to byte-address helper.
package boot_loader_pkg_rv32i;

    typedef enum logic [2:0] {
        RUN,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        RELEASE
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int CNT_W          = 16;

    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
        return {{(32-CNT_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/boot_loader_rv32i_if.sv
// Host byte link plus instruction-memory write port of the boot loader.
// master = the loader, slave = host/imem side.
interface boot_loader_rv32i_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_loader_rv32i_packer.sv
// Little-endian byte-lane packer: bytes land in lane byte_idx (lane 0 = bits 7:0);
// word_full flags the load that completes the word.
module byte_packer_rv32i
    import boot_loader_pkg_rv32i::*;
#(
    parameter int NUM_LANES = BYTES_PER_WORD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clr,
    input  logic [7:0]             din,
    output logic [NUM_LANES*8-1:0] word,
    output logic                   word_full
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [IDX_W-1:0]           byte_idx;
    logic [NUM_LANES-1:0][7:0]  lane_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      byte_idx <= '0;
        else if (clr)    byte_idx <= '0;
        else if (load)   byte_idx <= (byte_idx == IDX_W'(NUM_LANES-1)) ? '0 : byte_idx + 1'b1;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                  lane_q[l] <= '0;
            else if (clr)                                lane_q[l] <= '0;
            else if (load && byte_idx == IDX_W'(l))      lane_q[l] <= din;
        end
    end

    assign word      = lane_q;
    assign word_full = load && (byte_idx == IDX_W'(NUM_LANES-1));

endmodule

// File: rtl/boot_loader_rv32i.sv
// Boot/program-load controller: holds the RV32I core in reset, streams a
// length-prefixed image from the host byte link into imem, then releases the core.
module boot_loader_rv32i
    import boot_loader_pkg_rv32i::*;
#(
    parameter int          IMEM_DEPTH  = 256,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_req,
    boot_loader_rv32i_if.master  bus,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(IMEM_DEPTH);

    state_e              state;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    word_idx;
    logic [31:0]         timer;
    logic [31:0]         pk_word;
    logic                pk_full;

    logic                xfer;
    logic                pk_load;
    logic                pk_clr;
    logic [CNT_W-1:0]    hdr_count;
    logic                hdr_bad;
    logic                timed_out;
    logic [CNT_W-1:0]    word_nxt;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign pk_load   = xfer && (state == DATA);
    // Any new load starts from an empty word; WRITE drains the full one.
    assign pk_clr    = (state == WRITE) || (state == RUN && load_req);
    assign hdr_count = {bus.rx_data, count[7:0]};
    assign hdr_bad   = (hdr_count == '0) || ({1'b0, hdr_count} > DEPTH_L);
    assign timed_out = (TIMEOUT_CYC != 0) && (timer == TIMEOUT_CYC);
    assign word_nxt  = word_idx + 1'b1;

    byte_packer_rv32i #(.NUM_LANES(BYTES_PER_WORD)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pk_load),
        .clr       (pk_clr),
        .din       (bus.rx_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    assign bus.rx_ready   = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign bus.imem_we    = (state == WRITE);
    assign bus.imem_addr  = word_addr(word_idx);
    assign bus.imem_wdata = pk_word;
    assign busy           = (state != RUN);
    assign done           = (state == RELEASE);

    // core_rst_n tracks (next_state == RUN) so it moves on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            core_rst_n <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
            word_idx   <= '0;
            timer      <= '0;
        end else begin
            case (state)
                RUN: begin
                    core_rst_n <= 1'b1;
                    if (load_req) begin
                        state      <= HDR0;
                        core_rst_n <= 1'b0;
                        err        <= 1'b0;
                        word_idx   <= '0;
                        timer      <= '0;
                    end
                end
                HDR0, HDR1, DATA: begin
                    core_rst_n <= 1'b0;
                    if (xfer) begin
                        timer <= '0;
                        case (state)
                            HDR0: begin
                                count[7:0] <= bus.rx_data;
                                state      <= HDR1;
                            end
                            HDR1: begin
                                count[15:8] <= bus.rx_data;
                                if (hdr_bad) begin
                                    err   <= 1'b1;
                                    state <= RELEASE;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            default: if (pk_full) state <= WRITE;
                        endcase
                    end else if (timed_out) begin
                        err   <= 1'b1;
                        state <= RELEASE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                WRITE: begin
                    core_rst_n <= 1'b0;
                    word_idx   <= word_nxt;
                    state      <= (word_nxt == count) ? RELEASE : DATA;
                end
                RELEASE: begin
                    core_rst_n <= 1'b1;
                    state      <= RUN;
                end
                default: begin
                    core_rst_n <= 1'b1;
                    state      <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_rv32i.sv
// Scoreboard bench for boot_loader_rv32i: loads are modelled as byte streams,
// expected imem writes and done/err outcomes are queued and checked by a monitor.
module tb_boot_loader_rv32i;
    localparam int DEPTH = 256;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_req = 1'b0;
    logic core_rst_n, busy, done, err;

    boot_loader_rv32i_if bus();

    boot_loader_rv32i #(.IMEM_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    bit   done_q[$];
    int   done_seen = 0;
    bit   chk_rel = 0;
    logic [7:0] pay[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        bit  eb;
        if (rst_n) begin
            if (chk_rel) begin
                chk("core_released", core_rst_n, 1);
                chk("idle_after_release", busy, 0);
                chk_rel = 0;
            end
            if (busy && !done) chk("core_held_while_busy", core_rst_n, 0);
            if (bus.imem_we) begin
                chk("no_ready_in_write", bus.rx_ready, 0);
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", bus.imem_addr, bus.imem_wdata);
                end else begin
                    e = wr_q.pop_front();
                    chk("write_addr", bus.imem_addr, e.addr);
                    chk("write_data", bus.imem_wdata, e.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done pulse with err=%0d, none expected", err);
                end else begin
                    eb = done_q.pop_front();
                    chk("done_err", err, eb);
                    chk("core_held_in_release", core_rst_n, 0);
                    chk("ready_low_in_release", bus.rx_ready, 0);
                end
                chk_rel = 1;
                done_seen++;
            end
        end
    end

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // Byte is offered after a random idle gap and held until the link takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within 200 cycles", b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("core_rst_after_load_req", core_rst_n, 0);
        chk("busy_after_load_req", busy, 1);
        chk("err_cleared_by_load_req", err, 0);
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_seen == start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == start) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done pulse within 3000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    // Reference: count from the header; out-of-range count means error with no
    // writes; otherwise each complete group of 4 bytes is one LE word, and a
    // short payload ends in a timeout error.
    task automatic do_load(input int count, input bit pre, input bit mid_req);
        logic [15:0] c;
        bit   bad;
        int   start;
        int   nb;
        c   = count[15:0];
        nb  = pay.size();
        bad = (count == 0) || (count > DEPTH);
        if (bad) begin
            done_q.push_back(1'b1);
        end else begin
            for (int w = 0; w < nb / 4; w++)
                wr_q.push_back('{addr: 32'(w * 4),
                                 data: {pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]}});
            done_q.push_back(nb < count * 4);
        end
        start = done_seen;
        if (pre) begin
            bus.rx_data  = c[7:0];
            bus.rx_valid = 1'b1;
            repeat (3) @(negedge clk);
            pulse_load();
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end else begin
            pulse_load();
            send_byte(c[7:0]);
        end
        send_byte(c[15:8]);
        if (!bad) begin
            if (mid_req) begin
                load_req = 1'b1;
                @(negedge clk);
                load_req = 1'b0;
            end
            for (int i = 0; i < nb; i++) send_byte(pay[i]);
        end
        wait_done(start);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_core_rst_n", core_rst_n, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_rx_ready", bus.rx_ready, 0);
        chk("reset_imem_we", bus.imem_we, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        #1 chk("core_rst_n_before_edge", core_rst_n, 0);
        @(negedge clk);
        chk("core_rst_n_after_edge", core_rst_n, 1);

        pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        do_load(2, 0, 0);

        pay.delete();
        do_load(0, 0, 0);
        do_load(257, 1, 0);
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);

        fill_rand(4);
        do_load(1, 1, 1);
        for (int k = 0; k < 6; k++) begin
            int cnt;
            cnt = $urandom_range(1, 8);
            fill_rand(cnt * 4);
            do_load(cnt, 1'($urandom), 1'($urandom));
        end
        fill_rand(DEPTH * 4);
        do_load(DEPTH, 0, 0);

        fill_rand(5);
        do_load(2, 0, 0);
        fill_rand(8);
        do_load(3, 1, 0);

        pulse_load();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        chk("abort_core_rst_n", core_rst_n, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 0);
        chk("abort_rx_ready", bus.rx_ready, 0);
        chk("abort_imem_we", bus.imem_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_core_released", core_rst_n, 1);

        fill_rand(12);
        do_load(3, 0, 0);

        chk("pending_writes", wr_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
